// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_ADDR_W    = 18;
  localparam int unsigned SRAM_DATA_W    = 16;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned INDEX_W        = SRAM_ADDR_W - 1;
  localparam int unsigned CNT_W          = 4;
  localparam int unsigned DATA_BASE_ADDR = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Request captured from the memory stage when an access starts.
  typedef struct packed {
    logic              wr;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/sram_controller_if.sv
// Memory-stage request/response bus between the pipeline and the SRAM controller.
interface sram_controller_if;
  import sram_ctrl_pkg::*;

  logic              rd_en;
  logic              wr_en;
  logic [WORD_W-1:0] address;
  logic [WORD_W-1:0] write_data;
  logic [WORD_W-1:0] read_data;
  logic              ready;

  modport master (
    output rd_en, wr_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  rd_en, wr_en, address, write_data,
    output read_data, ready
  );

endinterface

// File: rtl/sram_controller.sv
// Splits one 32-bit MEM-stage access into two half-word accesses on a
// 16-bit asynchronous SRAM, each held for WAIT_CYCLES cycles.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DATA_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_controller_if.slave       mem_if,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_we_n
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  req_t                   req_q, req_d;
  logic [WORD_W-1:0]      rdata_q, rdata_d;
  logic [SRAM_ADDR_W-1:0] addr_d;
  logic [SRAM_DATA_W-1:0] dq_out_d;
  logic                   oe_d;
  logic                   we_n_d;
  logic [INDEX_W-1:0]     index_d;

  assign mem_if.read_data = rdata_q;

  // Combinational handshake so the pipeline freezes in the cycle a request appears.
  assign mem_if.ready = ((state_q == IDLE) && !mem_if.rd_en && !mem_if.wr_en) ||
                        (state_q == DONE);

  // State register, request latch, load data and registered SRAM pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rdata_q     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      sram_addr   <= addr_d;
      sram_dq_out <= dq_out_d;
      sram_dq_oe  <= oe_d;
      sram_we_n   <= we_n_d;
    end
  end

  // Next state, wait counter, read sampling, and pin values for the coming cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    rdata_d  = rdata_q;
    addr_d   = sram_addr;
    dq_out_d = '0;
    oe_d     = 1'b0;
    we_n_d   = 1'b1;
    index_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (mem_if.wr_en || mem_if.rd_en) begin
          // A simultaneous read and write is treated as a write.
          req_d   = '{wr: mem_if.wr_en, addr: mem_if.address, wdata: mem_if.write_data};
          cnt_d   = '0;
          state_d = LO;
        end
      end
      LO: begin
        if (cnt_q == CNT_LAST) begin
          if (!req_q.wr) rdata_d[15:0] = sram_dq_in;
          cnt_d   = '0;
          state_d = HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HI: begin
        if (cnt_q == CNT_LAST) begin
          if (!req_q.wr) rdata_d[31:16] = sram_dq_in;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The request still visible here is the one just finished; never restart from DONE.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are registered, so they are derived from where the FSM is heading.
    if ((state_d == LO) || (state_d == HI)) begin
      index_d = INDEX_W'((req_d.addr - WORD_W'(BASE_ADDR)) >> 2);
      addr_d  = {index_d, (state_d == HI)};
      if (req_d.wr) begin
        oe_d     = 1'b1;
        we_n_d   = 1'b0;
        dq_out_d = (state_d == HI) ? req_d.wdata[31:16] : req_d.wdata[15:0];
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: three controllers (W=1,2,15) share one request stream,
// each with its own behavioural 256Kx16 SRAM.
module tb_sram_controller;

  localparam int NI = 3;
  localparam int NC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;

  logic        rdy_w   [NI];
  logic        we_w    [NI];
  logic        oe_w    [NI];
  logic [17:0] addr_w  [NI];
  logic [15:0] dout_w  [NI];
  logic [31:0] rdata_w [NI];

  logic        rec_rdy [NI][NC];
  logic        rec_we  [NI][NC];
  logic        rec_a0  [NI][NC];
  logic [31:0] rec_rd  [NI][NC];

  int ws [NI] = '{1, 2, 15};
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int unsigned W = (g == 0) ? 1 : ((g == 1) ? 2 : 15);
    sram_controller_if bus ();
    logic [17:0] s_addr;
    logic [15:0] s_out;
    logic [15:0] s_in;
    logic        s_oe;
    logic        s_we_n;
    bit   [15:0] sram [0:262143];

    assign bus.rd_en      = rd_en;
    assign bus.wr_en      = wr_en;
    assign bus.address    = address;
    assign bus.write_data = write_data;
    assign s_in           = sram[s_addr];

    always @(s_we_n or s_addr or s_out) begin
      if (!s_we_n) sram[s_addr] = s_out;
    end

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_if      (bus),
      .sram_addr   (s_addr),
      .sram_dq_out (s_out),
      .sram_dq_oe  (s_oe),
      .sram_dq_in  (s_in),
      .sram_we_n   (s_we_n)
    );

    assign rdy_w[g]   = bus.ready;
    assign we_w[g]    = s_we_n;
    assign oe_w[g]    = s_oe;
    assign addr_w[g]  = s_addr;
    assign dout_w[g]  = s_out;
    assign rdata_w[g] = bus.read_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at cycle 0, drop enables after `hold` cycles, record ncyc cycles.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int hold, input int ncyc);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        rec_rdy[i][c] = rdy_w[i];
        rec_we[i][c]  = we_w[i];
        rec_a0[i][c]  = addr_w[i][0];
        rec_rd[i][c]  = rdata_w[i];
      end
      @(posedge clk); #1;
      if (c + 1 == hold) begin rd_en = 1'b0; wr_en = 1'b0; end
    end
  endtask

  // Ready-rise latency and per-phase write-strobe length for every instance.
  task automatic check_timing(input string name);
    int lo, hi, fr;
    for (int i = 0; i < NI; i++) begin
      lo = 0; hi = 0; fr = -1;
      for (int c = 0; c < 40; c++) begin
        if (!rec_we[i][c]) begin
          if (rec_a0[i][c]) hi++; else lo++;
        end
        if (c >= 1 && rec_rdy[i][c] && fr < 0) fr = c;
      end
      check($sformatf("%s W%0d lo len", name, ws[i]), 32'(lo), 32'(ws[i]));
      check($sformatf("%s W%0d hi len", name, ws[i]), 32'(hi), 32'(ws[i]));
      check($sformatf("%s W%0d ready at", name, ws[i]), 32'(fr), 32'(2 * ws[i] + 1));
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check("rst ready",   32'(rdy_w[1]), 32'd1);
    check("rst rdata",   rdata_w[1],    32'h0);
    check("rst addr",    32'(addr_w[1]), 32'h0);
    check("rst dq_out",  32'(dout_w[1]), 32'h0);
    check("rst oe",      32'(oe_w[1]),  32'd0);
    check("rst we_n",    32'(we_w[1]),  32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Write 0xDEADBEEF to 1024.
    run_op(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1, 40);
    for (int c = 0; c < 6; c++)
      check($sformatf("wr we_n c%0d", c), 32'(rec_we[1][c]), (c >= 1 && c <= 4) ? 32'd0 : 32'd1);
    check("wr ready c4", 32'(rec_rdy[1][4]), 32'd0);
    check("wr ready c5", 32'(rec_rdy[1][5]), 32'd1);
    check("wr half0", 32'(g_inst[1].sram[0]), 32'h0000BEEF);
    check("wr half1", 32'(g_inst[1].sram[1]), 32'h0000DEAD);
    check("wr rdata kept", rec_rd[1][39], 32'h0);
    check_timing("wr");

    // Read it back.
    run_op(1'b1, 1'b0, 32'd1024, 32'h0, 1, 40);
    check("rd ready c0", 32'(rec_rdy[1][0]), 32'd0);
    check("rd ready c4", 32'(rec_rdy[1][4]), 32'd0);
    check("rd ready c5", 32'(rec_rdy[1][5]), 32'd1);
    check("rd data c5", rec_rd[1][5], 32'hDEADBEEF);
    check("rd data W1", rec_rd[0][39], 32'hDEADBEEF);
    check("rd data W15", rec_rd[2][39], 32'hDEADBEEF);

    // Address mapping: 1036 and 1037 both land on halves 6/7.
    run_op(1'b0, 1'b1, 32'd1036, 32'h12345678, 1, 40);
    check("map 1036 half6", 32'(g_inst[1].sram[6]), 32'h00005678);
    check("map 1036 half7", 32'(g_inst[1].sram[7]), 32'h00001234);
    check_timing("map");
    run_op(1'b0, 1'b1, 32'd1037, 32'hCAFEF00D, 1, 40);
    check("map 1037 half6", 32'(g_inst[1].sram[6]), 32'h0000F00D);
    check("map 1037 half7", 32'(g_inst[1].sram[7]), 32'h0000CAFE);
    run_op(1'b1, 1'b0, 32'd1036, 32'h0, 1, 40);
    check("map rd 1036", rec_rd[1][5], 32'hCAFEF00D);

    // Back-to-back: request held through DONE, then a new one the cycle after.
    run_op(1'b1, 1'b0, 32'd1024, 32'h0, 6, 6);
    for (int c = 0; c < 5; c++)
      check($sformatf("b2b ready c%0d", c), 32'(rec_rdy[1][c]), 32'd0);
    check("b2b ready done", 32'(rec_rdy[1][5]), 32'd1);
    check("b2b data done", rec_rd[1][5], 32'hDEADBEEF);
    run_op(1'b1, 1'b0, 32'd1036, 32'h0, 1, 40);
    check("b2b2 ready c0", 32'(rec_rdy[1][0]), 32'd0);
    check("b2b2 data c1", rec_rd[1][1], 32'hDEADBEEF);
    check("b2b2 ready c4", 32'(rec_rdy[1][4]), 32'd0);
    check("b2b2 ready c5", 32'(rec_rdy[1][5]), 32'd1);
    check("b2b2 data c5", rec_rd[1][5], 32'hCAFEF00D);

    // Simultaneous read and write: the write wins.
    run_op(1'b1, 1'b1, 32'd1040, 32'h0BADC0DE, 1, 40);
    check("both we_n c1", 32'(rec_we[1][1]), 32'd0);
    check("both half8", 32'(g_inst[1].sram[8]), 32'h0000C0DE);
    check("both half9", 32'(g_inst[1].sram[9]), 32'h00000BAD);
    check("both rdata kept", rec_rd[1][39], 32'hCAFEF00D);

    // Reset in cycle 2 of a write releases the strobe immediately.
    run_op(1'b0, 1'b1, 32'd1044, 32'hFFFF0000, 1, 2);
    check("mid wr we_n", 32'(we_w[1]), 32'd0);
    rst = 1'b0;
    #1;
    check("async we_n", 32'(we_w[1]), 32'd1);
    check("async oe", 32'(oe_w[1]), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post rst ready", 32'(rdy_w[1]), 32'd1);
    check("post rst we_n", 32'(we_w[1]), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
